ocs_slot_switch: RTL and testbench
==================================

// Module: ocs_slot_switch
// PURPOSE
// - Behavioural 8-port optical circuit switch (OCS) for the ToR fabric; one instance per OCS plane (plane 0 = OCS0, plane 1 = OCS1).
// - Forwards each ToR uplink serial differential pair to exactly one other ToR downlink.
// - The permutation is chosen by the controller's slot id; a dark reconfiguration interval is inserted on every slot change.
// PARAMETERS
// - P_PORT_NUM        8    number of ToR ports (fixed 8; mod arithmetic is 3-bit)
// - P_OCS_ID          0    plane select: 0 = OCS0 offsets, 1 = OCS1 offsets
// - P_OFS_S0_OCS0     1    OCS0 destination offset in slot 0
// - P_OFS_S1_OCS0     2    OCS0 destination offset in slot 1
// - P_OFS_S0_OCS1     3    OCS1 destination offset in slot 0
// - P_OFS_S1_OCS1     4    OCS1 destination offset in slot 1
// - P_RECONFIG_CYCLES 234  dark cycles per reconfiguration (1..65535)
// PORTS
// - i_clk      in   1  single clock; all control logic runs on it
// - i_rst_n    in   1  asynchronous active-low reset
// - i_slot_id  in   1  controller slot id, asynchronous to i_clk
// - i_tor_txp  in   8  ToR uplink serial P; bit k = ToR k
// - i_tor_txn  in   8  ToR uplink serial N
// - o_tor_rxp  out  8  ToR downlink serial P; bit k = ToR k
// - o_tor_rxn  out  8  ToR downlink serial N
// BEHAVIOUR
// - Offset selection: ofs = table[P_OCS_ID][active_slot], 3 bits, range 1..7.
//   - Offset 0 (self-loop) is illegal and is not supported.
// - Connected mapping: o_tor_rxp[(i+ofs)%8] = i_tor_txp[i] and o_tor_rxn[(i+ofs)%8] = i_tor_txn[i], for all i.
//   - Mapping is a full permutation; the modulo wraps, e.g. with ofs=1, ToR7 feeds ToR0.
// - Data path is purely combinational through a mux on registered select lines; serial data is never registered.
// - Dark state: every output drives rxp=0, rxn=1 (static idle).
// - Control path:
//   - i_slot_id passes through a 2-flop synchroniser giving slot_s.
//   - slot_q is one further register; a change is flagged when slot_s != slot_q.
// - FSM states:
//   - DARK: counter counts up to P_RECONFIG_CYCLES-1; on wrap, active_slot <= slot_s and the FSM goes to CONN.
//   - CONN: drives the mapping from active_slot; a change flag moves the FSM to DARK with counter=0.
// - Reset values: state=DARK, counter=0, active_slot=0, sync/slot_q flops=0, all outputs dark (rxp=8'h00, rxn=8'hFF).
// - Latency: an edge on i_slot_id turns the outputs dark within 3 i_clk cycles.
//   - The new mapping appears exactly P_RECONFIG_CYCLES cycles after entering DARK.
// - Change during DARK: counter restarts at 0, and the slot sampled at wrap is the latest slot_s.
// - Reset mid-operation: outputs go dark immediately (asynchronously).
//   - After release, one full dark interval runs, then the plane connects per the synchronised slot.
// - No glitch between two mappings: any slot transition always passes through DARK.
// TESTING
// - Reset, release with i_slot_id=0, P_OCS_ID=0.
//   - Expect outputs dark (rxp=00, rxn=FF) for 234 cycles.
//   - Then drive txp=8'b0000_0001 and expect rxp=8'b0000_0010.
// - OCS0, slot toggled 0->1, txp=8'h01.
//   - Expect dark within 3 cycles, then rxp=8'h04 after 234 cycles; txp=8'h80 then gives rxp=8'h02 (wrap).
// - OCS1 instance (P_OCS_ID=1), txp=8'h01.
//   - Slot 0 gives rxp=8'h08; slot 1 gives rxp=8'h10.
//   - txn=~txp gives rxn=~rxp in both slots.
// - Slot toggles twice 100 cycles apart.
//   - Outputs stay dark until 234 cycles after the second change.
//   - Final mapping matches the final slot.
// - Assert i_rst_n while connected.
//   - Outputs go dark in the same timestep, without waiting for an i_clk edge.
//   - After release, a full dark interval precedes reconnection.
// - Random txp/txn patterns at every slot setting.
//   - Checker verifies the permutation is bijective and that no output ever mirrors its own input.

Source files
------------

// File: rtl/ocs_slot_switch_if.sv
// ocs_slot_switch_if
// Bundles the slot id and the ToR serial lanes of one OCS plane.
//   slot_id  : controller slot id, asynchronous to the switch clock
//   tor_txp/n: ToR uplink serial pairs, bit k = ToR k
//   tor_rxp/n: ToR downlink serial pairs, bit k = ToR k
// master = ToR/controller side (drives tx + slot), slave = switch side.
interface ocs_slot_switch_if #(
  parameter int P_PORT_NUM = 8
);
  logic                  slot_id;
  logic [P_PORT_NUM-1:0] tor_txp;
  logic [P_PORT_NUM-1:0] tor_txn;
  logic [P_PORT_NUM-1:0] tor_rxp;
  logic [P_PORT_NUM-1:0] tor_rxn;

  modport master (
    output slot_id, tor_txp, tor_txn,
    input  tor_rxp, tor_rxn
  );

  modport slave (
    input  slot_id, tor_txp, tor_txn,
    output tor_rxp, tor_rxn
  );
endinterface

// File: rtl/ocs_slot_switch.sv
// ocs_slot_switch
// Behavioural 8-port optical circuit switch, one instance per OCS plane.
// Each ToR uplink pair is forwarded to ToR (i+ofs)%8, where ofs is picked
// from the plane/slot offset table. Every slot change inserts a dark
// interval of P_RECONFIG_CYCLES clocks (rxp=0, rxn=1 on every port).
// Ports:
//   i_clk   : control clock
//   i_rst_n : asynchronous active-low reset (outputs go dark at once)
//   bus     : slave side of ocs_slot_switch_if (slot id, tx in, rx out)

// One downlink lane: picks its source uplink from the current offset, or
// drives the static idle level while the plane is dark.
module ocs_lane #(
  parameter int P_PORT_NUM = 8,
  parameter int LANE       = 0
) (
  input  logic [P_PORT_NUM-1:0] txp,
  input  logic [P_PORT_NUM-1:0] txn,
  input  logic [2:0]            ofs,
  input  logic                  conn,
  output logic                  rxp,
  output logic                  rxn
);
  localparam logic [2:0] L_IDX = 3'(LANE);

  // Inverse of dst = src + ofs; 3-bit subtraction gives the mod-8 wrap.
  logic [2:0] src;
  assign src = L_IDX - ofs;

  always_comb begin
    rxp = conn ? txp[src] : 1'b0;
    rxn = conn ? txn[src] : 1'b1;
  end
endmodule

module ocs_slot_switch #(
  parameter int P_PORT_NUM        = 8,
  parameter int P_OCS_ID          = 0,
  parameter int P_OFS_S0_OCS0     = 1,
  parameter int P_OFS_S1_OCS0     = 2,
  parameter int P_OFS_S0_OCS1     = 3,
  parameter int P_OFS_S1_OCS1     = 4,
  parameter int P_RECONFIG_CYCLES = 234
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ocs_slot_switch_if.slave   bus
);
  localparam logic [15:0] L_LAST = 16'(P_RECONFIG_CYCLES - 1);
  localparam logic [2:0]  L_OFS_S0 = (P_OCS_ID == 0) ? 3'(P_OFS_S0_OCS0) : 3'(P_OFS_S0_OCS1);
  localparam logic [2:0]  L_OFS_S1 = (P_OCS_ID == 0) ? 3'(P_OFS_S1_OCS0) : 3'(P_OFS_S1_OCS1);

  typedef enum logic {S_DARK, S_CONN} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        active_slot, active_nxt;
  logic        sync1, slot_s, slot_q;
  logic        chg;
  logic        conn;
  logic [2:0]  ofs;

  // Slot id is asynchronous: two-flop synchroniser, then one more flop so
  // a change is seen as a single-cycle mismatch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1  <= 1'b0;
      slot_s <= 1'b0;
      slot_q <= 1'b0;
    end else begin
      sync1  <= bus.slot_id;
      slot_s <= sync1;
      slot_q <= slot_s;
    end
  end

  assign chg = (slot_s != slot_q);

  // State register (with the dark counter and latched slot)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_DARK;
      cnt         <= '0;
      active_slot <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      active_slot <= active_nxt;
    end
  end

  // Next-state logic. A change while dark restarts the interval so the
  // slot latched at the wrap is always the newest synchronised value.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    active_nxt = active_slot;
    case (state)
      S_DARK: begin
        if (chg) begin
          cnt_nxt = '0;
        end else if (cnt == L_LAST) begin
          cnt_nxt    = '0;
          active_nxt = slot_s;
          state_nxt  = S_CONN;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_CONN: begin
        if (chg) begin
          cnt_nxt   = '0;
          state_nxt = S_DARK;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_DARK;
      end
    endcase
  end

  // Output decode: select lines come only from registered state, so the
  // serial path is a pure mux with no clocked element.
  always_comb begin
    conn = (state == S_CONN);
    ofs  = active_slot ? L_OFS_S1 : L_OFS_S0;
  end

  logic [P_PORT_NUM-1:0] rxp_w, rxn_w;

  for (genvar g = 0; g < P_PORT_NUM; g++) begin : g_lane
    ocs_lane #(
      .P_PORT_NUM (P_PORT_NUM),
      .LANE       (g)
    ) u_lane (
      .txp  (bus.tor_txp),
      .txn  (bus.tor_txn),
      .ofs  (ofs),
      .conn (conn),
      .rxp  (rxp_w[g]),
      .rxn  (rxn_w[g])
    );
  end

  assign bus.tor_rxp = rxp_w;
  assign bus.tor_rxn = rxn_w;
endmodule

// File: tb/tb_ocs_slot_switch.sv
module tb_ocs_slot_switch;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  ocs_slot_switch_if #(.P_PORT_NUM(8)) if0 ();
  ocs_slot_switch_if #(.P_PORT_NUM(8)) if1 ();

  ocs_slot_switch #(.P_OCS_ID(0)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0.slave)
  );

  ocs_slot_switch #(.P_OCS_ID(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       slot;
    logic [7:0] txp, txn;
    logic [7:0] e0p, e0n, e1p, e1n;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic slot, input logic [7:0] txp, input logic [7:0] txn);
    if0.slot_id = slot; if0.tor_txp = txp; if0.tor_txn = txn;
    if1.slot_id = slot; if1.tor_txp = txp; if1.tor_txn = txn;
  endtask

  task automatic chk_dark(input string nm);
    chk({nm, "_dark0"}, {if0.tor_rxp, if0.tor_rxn}, 16'h00FF);
    chk({nm, "_dark1"}, {if1.tor_rxp, if1.tor_rxn}, 16'h00FF);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  // Hand-table of plane offsets, independent of the DUT parameters.
  function automatic int exp_ofs(input int plane, input int slot);
    if (plane == 0) return (slot == 0) ? 1 : 2;
    return (slot == 0) ? 3 : 4;
  endfunction

  initial begin
    logic       cur_slot;
    logic [7:0] mask0, mask1, r;
    n_pass = 0;
    n_tot  = 0;

    vecs[0] = '{"s0_bit0", 1'b0, 8'h01, 8'hFE, 8'h02, 8'hFD, 8'h08, 8'hF7};
    vecs[1] = '{"s0_bit7", 1'b0, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h04, 8'hFB};
    vecs[2] = '{"s1_bit0", 1'b1, 8'h01, 8'hFE, 8'h04, 8'hFB, 8'h10, 8'hEF};
    vecs[3] = '{"s1_bit7", 1'b1, 8'h80, 8'h7F, 8'h02, 8'hFD, 8'h08, 8'hF7};
    vecs[4] = '{"s1_a5",   1'b1, 8'hA5, 8'h0F, 8'h96, 8'h3C, 8'h5A, 8'hF0};
    vecs[5] = '{"s0_a5",   1'b0, 8'hA5, 8'h0F, 8'h4B, 8'h1E, 8'h2D, 8'h78};

    // Reset and first dark interval
    rst_n = 1'b0;
    drive(1'b0, 8'h01, 8'hFE);
    #1 chk_dark("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (233) @(posedge clk);
    #1 chk_dark("init_233");
    @(posedge clk);
    #1 chk("init_conn_rxp0", if0.tor_rxp, 8'h02);
    chk("init_conn_rxp1", if1.tor_rxp, 8'h08);

    // Slot 0 -> 1: dark within 3 cycles, reconnect 234 after entering dark
    @(negedge clk) drive(1'b1, 8'h01, 8'hFE);
    repeat (3) @(posedge clk);
    #1 chk_dark("tog_3cyc");
    repeat (233) @(posedge clk);
    #1 chk_dark("tog_236");
    @(posedge clk);
    #1 chk("tog_rxp0", if0.tor_rxp, 8'h04);
    chk("tog_rxp1", if1.tor_rxp, 8'h10);
    drive(1'b1, 8'h80, 8'h7F);
    #1 chk("tog_wrap_rxp0", if0.tor_rxp, 8'h02);

    // Two changes 100 cycles apart: dark interval restarts on the second
    @(negedge clk) drive(1'b0, 8'h01, 8'hFE);
    repeat (100) @(posedge clk);
    #1 chk_dark("dbl_mid");
    @(negedge clk) drive(1'b1, 8'h01, 8'hFE);
    repeat (236) @(posedge clk);
    #1 chk_dark("dbl_236");
    @(posedge clk);
    #1 chk("dbl_rxp0", if0.tor_rxp, 8'h04);
    chk("dbl_rxp1", if1.tor_rxp, 8'h10);

    // Reset while connected: dark without any clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_dark("rst_async");
    @(negedge clk) rst_n = 1'b1;
    repeat (236) @(posedge clk);
    #1 chk_dark("rst_236");
    @(posedge clk);
    #1 chk("rst_rxp0", if0.tor_rxp, 8'h04);
    chk("rst_rxp1", if1.tor_rxp, 8'h10);
    cur_slot = 1'b1;

    // Table-driven vectors; slot changes wait out the dark interval
    for (int v = 0; v < 6; v++) begin
      @(negedge clk) drive(vecs[v].slot, vecs[v].txp, vecs[v].txn);
      if (vecs[v].slot != cur_slot) repeat (240) @(posedge clk);
      cur_slot = vecs[v].slot;
      #1;
      chk({vecs[v].name, "_rxp0"}, if0.tor_rxp, vecs[v].e0p);
      chk({vecs[v].name, "_rxn0"}, if0.tor_rxn, vecs[v].e0n);
      chk({vecs[v].name, "_rxp1"}, if1.tor_rxp, vecs[v].e1p);
      chk({vecs[v].name, "_rxn1"}, if1.tor_rxn, vecs[v].e1n);
    end

    // Permutation properties and random patterns at every slot
    for (int s = 0; s < 2; s++) begin
      @(negedge clk) drive(s[0], 8'h00, 8'hFF);
      if (s[0] != cur_slot) repeat (240) @(posedge clk);
      cur_slot = s[0];
      mask0 = '0;
      mask1 = '0;
      for (int i = 0; i < 8; i++) begin
        r = 8'h01 << i;
        drive(s[0], r, ~r);
        #1;
        chk("walk_onehot0", int'($onehot(if0.tor_rxp)), 1);
        chk("walk_onehot1", int'($onehot(if1.tor_rxp)), 1);
        chk("walk_noself0", int'(if0.tor_rxp[i]), 0);
        chk("walk_noself1", int'(if1.tor_rxp[i]), 0);
        mask0 |= if0.tor_rxp;
        mask1 |= if1.tor_rxp;
      end
      chk("bijective0", mask0, 8'hFF);
      chk("bijective1", mask1, 8'hFF);
      for (int k = 0; k < 6; k++) begin
        logic [7:0] tp, tn;
        tp = 8'($urandom);
        tn = 8'($urandom);
        drive(s[0], tp, tn);
        #1;
        chk("rand_rxp0", if0.tor_rxp, rotl(tp, exp_ofs(0, s)));
        chk("rand_rxn0", if0.tor_rxn, rotl(tn, exp_ofs(0, s)));
        chk("rand_rxp1", if1.tor_rxp, rotl(tp, exp_ofs(1, s)));
        chk("rand_rxn1", if1.tor_rxn, rotl(tn, exp_ofs(1, s)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
